axil_ni_bridge: RTL and testbench
=================================

Name: axil_ni_bridge

Overview:
- AXI4-Lite slave to Native Interface (NI) master bridge. It sits directly upstream of NI register slaves.
- Converts each AXI4-Lite write or read into a single NI write (wen/wack) or read (ren/rvalid) transaction, with one transaction outstanding at a time.
- A response timeout prevents a dead NI slave from hanging the bus.

Parameters:
- DATA_WIDTH, 32, data width on both the AXI and NI sides.
- ADDR_WIDTH, 16, address width on both sides; addresses pass through unmodified.
- TIMEOUT_CYCLES, 256, cycles to wait for wack/rvalid before erroring; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_WIDTH  AXI write address
- s_awvalid  in  1
- s_awready  out  1
- s_wdata  in  DATA_WIDTH
- s_wstrb  in  DATA_WIDTH/8
- s_wvalid  in  1
- s_wready  out  1
- s_bresp  out  2
- s_bvalid  out  1
- s_bready  in  1
- s_araddr  in  ADDR_WIDTH
- s_arvalid  in  1
- s_arready  out  1
- s_rdata  out  DATA_WIDTH
- s_rresp  out  2
- s_rvalid  out  1
- s_rready  in  1
- ni_wen  out  1  one-cycle write strobe
- ni_waddr  out  ADDR_WIDTH
- ni_wdata  out  DATA_WIDTH
- ni_wack  in  1  write acknowledge
- ni_ren  out  1  one-cycle read strobe
- ni_raddr  out  ADDR_WIDTH
- ni_rdata  in  DATA_WIDTH
- ni_rvalid  in  1  read data valid

Behaviour:
- Reset (rstn low, asynchronous): every ready/valid/strobe output is 0, bresp/rresp/rdata/ni_* address and data are 0, state is IDLE, AW/W holding flags are cleared, and the arbiter favours writes.
- AW and W are accepted independently.
  - s_awready = IDLE and AW not held.
  - s_wready = IDLE and W not held.
  - Each handshake latches its payload and sets its held flag.
- Arbitration in IDLE:
  - A write is ready when AW and W are both held.
  - A read is ready when s_arvalid is high.
  - s_arready is high only in a cycle where a read is granted.
  - If both are ready, grant the one not granted last, then toggle the favour.
- Write grant:
  - If s_wstrb held is not all-ones, no NI access is made; go to WR_RESP with bresp=SLVERR (2'b10).
  - Otherwise go to WR_REQ.
- WR_REQ (1 cycle): ni_wen=1, ni_waddr/ni_wdata driven from the latches. Next state is WR_WAIT.
- WR_WAIT:
  - ni_wack=1 goes to WR_RESP with bresp=OKAY.
  - Timeout expiry goes to WR_RESP with bresp=SLVERR.
- WR_RESP:
  - s_bvalid=1 is held until s_bready.
  - On the handshake, clear both held flags and return to IDLE.
- Read grant (AR handshake): latch s_araddr and go to RD_REQ.
- RD_REQ (1 cycle): ni_ren=1, ni_raddr driven. Next state is RD_WAIT.
- RD_WAIT:
  - ni_rvalid=1 captures ni_rdata into s_rdata with rresp=OKAY and goes to RD_RESP.
  - Timeout gives s_rdata=0, rresp=SLVERR.
- RD_RESP: s_rvalid=1 is held until s_rready, then return to IDLE.
- Latency: NI strobe 1 cycle after grant; AXI response valid 1 cycle after wack/rvalid.
- Ack sampling:
  - ni_wack/ni_rvalid are sampled only in WR_WAIT/RD_WAIT, i.e. from the cycle after the strobe onward.
  - An ack in the strobe cycle itself or in any other state is ignored, including late acks after a timeout.
- Timeout counter:
  - Clears on entering a WAIT state and increments each WAIT cycle.
  - Expiry when count == TIMEOUT_CYCLES-1 and no ack in that cycle.
  - An ack in the expiry cycle wins (OKAY).
  - Width is $clog2(TIMEOUT_CYCLES+1).
- ni_waddr/ni_wdata/ni_raddr hold their last values outside the strobe cycles.
- Only one transaction is ever in flight; AW/W may pre-load during a read but are not accepted while non-IDLE.

Test Plan:
- Write with AW and W in the same cycle: addr 0x0010, data 0xDEADBEEF, wstrb 0xF, wack 2 cycles after wen. Required: single-cycle wen with waddr=0x0010, wdata=0xDEADBEEF; bvalid with bresp=OKAY the cycle after wack.
- W two cycles before AW: addr 0x0004, data 0x12345678. Required: no wen until AW is accepted, then a single write with correct address and data.
- Read from addr 0x0020, rvalid 1 cycle after ren with rdata 0xCAFEF00D, rready stalled 3 cycles. Required: s_rdata=0xCAFEF00D, rresp=OKAY, s_rvalid held 4 cycles.
- Write and read ready in the same IDLE cycle, twice in succession. Required: first write, then read, then write, then read (alternating grants).
- TIMEOUT_CYCLES=4, read with no rvalid. Required: s_rvalid with rresp=SLVERR, rdata=0; a late rvalid afterwards is ignored. Also wstrb=0x3 gives bresp=SLVERR with no wen pulse.
- rstn asserted in WR_WAIT. Required: all outputs 0 immediately; after release the bridge is in IDLE and accepts a new write normally.

Source files
------------

// File: rtl/axil_ni_bridge.sv
// rtl/axil_ni_bridge.sv - AXI4-Lite slave to NI master bridge, one transaction in flight
module axil_ni_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      ni_wen,
  output logic [ADDR_WIDTH-1:0]     ni_waddr,
  output logic [DATA_WIDTH-1:0]     ni_wdata,
  input  logic                      ni_wack,
  output logic                      ni_ren,
  output logic [ADDR_WIDTH-1:0]     ni_raddr,
  input  logic [DATA_WIDTH-1:0]     ni_rdata,
  input  logic                      ni_rvalid
);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                    fav_wr_q, fav_wr_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, ni_waddr_q, ni_waddr_d, ni_raddr_q, ni_raddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, ni_wdata_q, ni_wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_ready, rd_ready, wr_grant, rd_grant, aw_hs, w_hs, timeout_hit;

  // Contention goes to whichever side was not granted last.
  always_comb begin
    wr_ready    = aw_held_q && w_held_q;
    rd_ready    = s_arvalid;
    wr_grant    = (state_q == IDLE) && wr_ready && (!rd_ready || fav_wr_q);
    rd_grant    = (state_q == IDLE) && rd_ready && !wr_grant;
    aw_hs       = s_awvalid && s_awready;
    w_hs        = s_wvalid && s_wready;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      fav_wr_q   <= 1'b1;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ni_waddr_q <= '0;
      ni_wdata_q <= '0;
      ni_raddr_q <= '0;
      rdata_q    <= '0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      fav_wr_q   <= fav_wr_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ni_waddr_q <= ni_waddr_d;
      ni_wdata_q <= ni_wdata_d;
      ni_raddr_q <= ni_raddr_d;
      rdata_q    <= rdata_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_grant)      state_d = (&wstrb_q) ? WR_REQ : WR_RESP;
        else if (rd_grant) state_d = RD_REQ;
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: if (ni_wack || timeout_hit) state_d = WR_RESP;
      WR_RESP: if (s_bready) state_d = IDLE;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (ni_rvalid || timeout_hit) state_d = RD_RESP;
      RD_RESP: if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    fav_wr_d   = fav_wr_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ni_waddr_d = ni_waddr_q;
    ni_wdata_d = ni_wdata_q;
    ni_raddr_d = ni_raddr_q;
    rdata_d    = rdata_q;
    bresp_d    = bresp_q;
    rresp_d    = rresp_q;
    cnt_d      = cnt_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    if (wr_grant) begin
      fav_wr_d = 1'b0;
      bresp_d  = (&wstrb_q) ? 2'b00 : 2'b10;
      if (&wstrb_q) begin
        ni_waddr_d = awaddr_q;
        ni_wdata_d = wdata_q;
      end
    end
    if (rd_grant) begin
      fav_wr_d   = 1'b1;
      ni_raddr_d = s_araddr;
    end
    if (state_q == WR_REQ || state_q == RD_REQ) cnt_d = '0;
    if (state_q == WR_WAIT || state_q == RD_WAIT) cnt_d = cnt_q + CNT_W'(1);
    // A real ack in the expiry cycle takes priority over the timeout.
    if (state_q == WR_WAIT) begin
      if (ni_wack)          bresp_d = 2'b00;
      else if (timeout_hit) bresp_d = 2'b10;
    end
    if (state_q == RD_WAIT) begin
      if (ni_rvalid) begin
        rdata_d = ni_rdata;
        rresp_d = 2'b00;
      end else if (timeout_hit) begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end
    end
    if (state_q == WR_RESP && s_bready) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Readies are gated by rstn so they are low for the whole reset window.
  always_comb begin
    s_awready = rstn && (state_q == IDLE) && !aw_held_q;
    s_wready  = rstn && (state_q == IDLE) && !w_held_q;
    s_arready = rstn && rd_grant;
    s_bvalid  = (state_q == WR_RESP);
    s_rvalid  = (state_q == RD_RESP);
    ni_wen    = (state_q == WR_REQ);
    ni_ren    = (state_q == RD_REQ);
    s_bresp   = bresp_q;
    s_rresp   = rresp_q;
    s_rdata   = rdata_q;
    ni_waddr  = ni_waddr_q;
    ni_wdata  = ni_wdata_q;
    ni_raddr  = ni_raddr_q;
  end
endmodule

// File: tb/tb_axil_ni_bridge.sv
// tb/tb_axil_ni_bridge.sv - directed self-checking bench for axil_ni_bridge
module tb_axil_ni_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [DW/8-1:0] s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b0;
  logic          ni_wen;
  logic [AW-1:0] ni_waddr;
  logic [DW-1:0] ni_wdata;
  logic          ni_wack = 1'b0;
  logic          ni_ren;
  logic [AW-1:0] ni_raddr;
  logic [DW-1:0] ni_rdata = '0;
  logic          ni_rvalid = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  axil_ni_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ni_wen(ni_wen), .ni_waddr(ni_waddr), .ni_wdata(ni_wdata), .ni_wack(ni_wack),
    .ni_ren(ni_ren), .ni_raddr(ni_raddr), .ni_rdata(ni_rdata), .ni_rvalid(ni_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output int which);
    which = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ni_wen) begin which = 1; break; end
      if (ni_ren) begin which = 2; break; end
    end
  endtask

  task automatic finish_write();
    tick();
    ni_wack = 1'b1;
    tick();
    ni_wack = 1'b0;
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask

  task automatic finish_read(input logic [DW-1:0] data);
    tick();
    ni_rvalid = 1'b1;
    ni_rdata = data;
    tick();
    ni_rvalid = 1'b0;
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    logic [DW*3+AW*3+3:0] dat;
    s_arvalid = 1'b1;
    tick();
    tick();
    ctl = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, ni_wen, ni_ren};
    dat = {s_bresp, s_rresp, s_rdata, ni_waddr, ni_wdata, ni_raddr, ni_rdata, s_awaddr};
    tests_run++;
    if (ctl !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b expected 0000000", ctl);
    end
    tests_run++;
    if (dat !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0", dat);
    end
    s_arvalid = 1'b0;
    rstn = 1'b1;
    #1;
    tests_run++;
    if ({s_awready, s_wready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_idle_ready: got %b expected 11", {s_awready, s_wready});
    end
    tick();
  endtask

  task automatic test_write_same_cycle();
    s_awaddr = 16'h0010; s_awvalid = 1'b1;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    tests_run++;
    if ({ni_wen, ni_waddr, ni_wdata} !== {1'b1, 16'h0010, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL wr1_strobe: got wen=%b addr=%h data=%h expected 1/0010/deadbeef", ni_wen, ni_waddr, ni_wdata);
    end
    tick();
    tests_run++;
    if (ni_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr1_single_wen: got %b expected 0", ni_wen);
    end
    tick();
    ni_wack = 1'b1;
    tests_run++;
    if (s_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr1_early_bvalid: got %b expected 0", s_bvalid);
    end
    tick();
    ni_wack = 1'b0;
    tests_run++;
    if ({s_bvalid, s_bresp} !== 3'b100) begin
      tests_failed++;
      $display("FAIL wr1_bresp: got bvalid=%b bresp=%b expected 1/00", s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    tests_run++;
    if (s_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr1_bvalid_drop: got %b expected 0", s_bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    logic saw;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    saw = ni_wen;
    tick();
    saw |= ni_wen;
    s_awaddr = 16'h0004; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    saw |= ni_wen;
    tests_run++;
    if (saw !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr2_no_early_wen: got %b expected 0", saw);
    end
    tick();
    tests_run++;
    if ({ni_wen, ni_waddr, ni_wdata} !== {1'b1, 16'h0004, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL wr2_strobe: got wen=%b addr=%h data=%h expected 1/0004/12345678", ni_wen, ni_waddr, ni_wdata);
    end
    finish_write();
  endtask

  task automatic test_read();
    int hold;
    s_araddr = 16'h0020; s_arvalid = 1'b1;
    #1;
    tests_run++;
    if (s_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_arready: got %b expected 1", s_arready);
    end
    tick();
    s_arvalid = 1'b0;
    tests_run++;
    if ({ni_ren, ni_raddr} !== {1'b1, 16'h0020}) begin
      tests_failed++;
      $display("FAIL rd_strobe: got ren=%b addr=%h expected 1/0020", ni_ren, ni_raddr);
    end
    tick();
    ni_rvalid = 1'b1; ni_rdata = 32'hCAFEF00D;
    tick();
    ni_rvalid = 1'b0; ni_rdata = '0;
    tests_run++;
    if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'hCAFEF00D}) begin
      tests_failed++;
      $display("FAIL rd_data: got rvalid=%b rresp=%b rdata=%h expected 1/00/cafef00d", s_rvalid, s_rresp, s_rdata);
    end
    hold = 0;
    for (int i = 0; i < 8 && s_rvalid; i++) begin
      hold++;
      if (hold == 4) s_rready = 1'b1;
      tick();
    end
    s_rready = 1'b0;
    tests_run++;
    if (hold !== 4) begin
      tests_failed++;
      $display("FAIL rd_hold: got %0d cycles expected 4", hold);
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    for (int r = 0; r < 2; r++) begin
      s_awaddr = 16'h0030 + 16'(r); s_awvalid = 1'b1;
      s_wdata = 32'hA0 + 32'(r); s_wstrb = 4'hF; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 16'h0040 + 16'(r); s_arvalid = 1'b1;
      wait_strobe(w1);
      if (w1 == 2) begin s_arvalid = 1'b0; finish_read(32'h1); end
      else if (w1 == 1) finish_write();
      wait_strobe(w2);
      if (w2 == 2) begin s_arvalid = 1'b0; finish_read(32'h2); end
      else if (w2 == 1) finish_write();
      s_arvalid = 1'b0;
      tests_run++;
      if (w1 !== 1) begin
        tests_failed++;
        $display("FAIL b2b_round%0d_first: got %0d expected 1 (write)", r, w1);
      end
      tests_run++;
      if (w2 !== 2) begin
        tests_failed++;
        $display("FAIL b2b_round%0d_second: got %0d expected 2 (read)", r, w2);
      end
    end
  endtask

  task automatic test_timeout_and_strobe();
    int n;
    logic saw;
    s_araddr = 16'h0050; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && !s_rvalid; i++) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 5) begin
      tests_failed++;
      $display("FAIL to_latency: got %0d cycles expected 5", n);
    end
    tests_run++;
    if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      tests_failed++;
      $display("FAIL to_resp: got rvalid=%b rresp=%b rdata=%h expected 1/10/00000000", s_rvalid, s_rresp, s_rdata);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    ni_rvalid = 1'b1; ni_rdata = 32'h00000099;
    tick();
    ni_rvalid = 1'b0;
    tick();
    tests_run++;
    if ({s_rvalid, s_awready, s_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL to_late_rvalid: got rvalid=%b awready=%b rdata=%h expected 0/1/00000000", s_rvalid, s_awready, s_rdata);
    end
    s_awaddr = 16'h0060; s_awvalid = 1'b1;
    s_wdata = 32'h0000AAAA; s_wstrb = 4'h3; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    saw = ni_wen;
    for (int i = 0; i < 6 && !s_bvalid; i++) begin
      tick();
      saw |= ni_wen;
    end
    tests_run++;
    if ({saw, s_bvalid, s_bresp} !== {1'b0, 1'b1, 2'b10}) begin
      tests_failed++;
      $display("FAIL strb_slverr: got wen_seen=%b bvalid=%b bresp=%b expected 0/1/10", saw, s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [AW+DW+3:0] obs;
    s_awaddr = 16'h0070; s_awvalid = 1'b1;
    s_wdata = 32'h00005555; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    obs = {ni_waddr, ni_wdata, ni_wen, s_bvalid, s_awready, s_wready};
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %h expected 0", obs);
    end
    tick();
    rstn = 1'b1;
    s_awaddr = 16'h0080; s_awvalid = 1'b1;
    s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    #1;
    tests_run++;
    if ({s_awready, s_wready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rst_mid_idle: got %b expected 11", {s_awready, s_wready});
    end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    tests_run++;
    if ({ni_wen, ni_waddr, ni_wdata} !== {1'b1, 16'h0080, 32'h0BADF00D}) begin
      tests_failed++;
      $display("FAIL rst_mid_write: got wen=%b addr=%h data=%h expected 1/0080/0badf00d", ni_wen, ni_waddr, ni_wdata);
    end
    tick();
    ni_wack = 1'b1;
    tick();
    ni_wack = 1'b0;
    tests_run++;
    if ({s_bvalid, s_bresp} !== 3'b100) begin
      tests_failed++;
      $display("FAIL rst_mid_bresp: got bvalid=%b bresp=%b expected 1/00", s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read();
    test_back_to_back();
    test_timeout_and_strobe();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
